// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive/transmit engines: state encodings,
// counter width default and the default baud_k table for a 100 MHz clock.
package uart_rx_engine_pkg;

  localparam int K_WIDTH_DEF = 19;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // baud_k = round_down(100 MHz / baud) - 1 for the 12 selectable rates
  function automatic logic [K_WIDTH_DEF-1:0] default_baud_k(input logic [3:0] sel);
    logic [K_WIDTH_DEF-1:0] k;
    case (sel)
      4'd0:    k = 19'd333332; // 300
      4'd1:    k = 19'd166665; // 600
      4'd2:    k = 19'd83332;  // 1200
      4'd3:    k = 19'd41665;  // 2400
      4'd4:    k = 19'd20832;  // 4800
      4'd5:    k = 19'd10415;  // 9600
      4'd6:    k = 19'd6943;   // 14400
      4'd7:    k = 19'd5207;   // 19200
      4'd8:    k = 19'd2603;   // 38400
      4'd9:    k = 19'd1735;   // 57600
      4'd10:   k = 19'd867;    // 115200
      4'd11:   k = 19'd433;    // 230400
      default: k = 19'd10415;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter shared by the receive and transmit engines: counts up from a
// clear, flagging the half-bit and full-bit points of the current bit time.
module uart_bit_timer
  import uart_rx_engine_pkg::*;
#(
  parameter int K_WIDTH = K_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [K_WIDTH-1:0] limit,
  output logic               mid_tick,
  output logic               bit_tick
);

  logic [K_WIDTH-1:0] cnt_reg;

  // The owning FSM clears on every tick, so the counter never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign mid_tick = (cnt_reg == (limit >> 1));
  assign bit_tick = (cnt_reg == limit);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises rx, frames start/data/parity/stop bits and
// presents the character with a one-cycle rx_done plus parity/framing flags.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int K_WIDTH = K_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic [K_WIDTH-1:0] baud_k,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  output logic [7:0]         rx_data,
  output logic               rx_done,
  output logic               perr,
  output logic               ferr,
  output logic               busy
);

  rx_state_t          state_reg, state_next;
  logic               rx_meta_reg, rx_sync_reg;
  logic [K_WIDTH-1:0] baud_k_reg;
  logic               eight_reg, pen_reg, ohel_reg;
  logic [7:0]         shift_reg;
  logic [3:0]         bit_idx_reg;
  logic               p_rx_reg;
  logic [7:0]         rx_data_reg;
  logic               rx_done_reg, perr_reg, ferr_reg;

  logic               tmr_clear, mid_tick, bit_tick;
  logic               start_det, sample_data, sample_stop;
  logic [3:0]         last_idx, par_idx;
  logic [7:0]         char_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  uart_bit_timer #(.K_WIDTH(K_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .limit    (baud_k_reg),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  // Index of the final data-or-parity bit, and of the parity bit when enabled
  assign last_idx = (eight_reg ? 4'd7 : 4'd6) + {3'b000, pen_reg};
  assign par_idx  = eight_reg ? 4'd8 : 4'd7;
  assign char_c   = eight_reg ? shift_reg : {1'b0, shift_reg[7:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RX_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    tmr_clear   = 1'b0;
    start_det   = 1'b0;
    sample_data = 1'b0;
    sample_stop = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        tmr_clear = 1'b1;
        if (!rx_sync_reg) begin
          state_next = RX_START;
          start_det  = 1'b1;
        end
      end
      RX_START: begin
        if (mid_tick) begin
          tmr_clear  = 1'b1;
          state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          tmr_clear   = 1'b1;
          sample_data = 1'b1;
          if (bit_idx_reg == last_idx) begin
            state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          tmr_clear   = 1'b1;
          sample_stop = 1'b1;
          state_next  = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_k_reg  <= '0;
      eight_reg   <= 1'b0;
      pen_reg     <= 1'b0;
      ohel_reg    <= 1'b0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      p_rx_reg    <= 1'b0;
      rx_data_reg <= '0;
      rx_done_reg <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      rx_done_reg <= 1'b0;
      if (start_det) begin
        baud_k_reg  <= baud_k;
        eight_reg   <= eight;
        pen_reg     <= pen;
        ohel_reg    <= ohel;
        bit_idx_reg <= '0;
      end
      if (sample_data) begin
        bit_idx_reg <= bit_idx_reg + 1'b1;
        if (pen_reg && (bit_idx_reg == par_idx)) begin
          p_rx_reg <= rx_sync_reg;
        end else begin
          shift_reg <= {rx_sync_reg, shift_reg[7:1]};
        end
      end
      if (sample_stop) begin
        rx_done_reg <= 1'b1;
        rx_data_reg <= char_c;
        ferr_reg    <= ~rx_sync_reg;
        perr_reg    <= pen_reg & (^char_c ^ p_rx_reg ^ ohel_reg);
      end
    end
  end

  assign rx_data = rx_data_reg;
  assign rx_done = rx_done_reg;
  assign perr    = perr_reg;
  assign ferr    = ferr_reg;
  assign busy    = (state_reg != RX_IDLE);

endmodule
